// File: rtl/capture_wr_arbiter_if.sv
// Bundle of requester-side capture write channels and the shared AXI write master port.
// The master modport is the arbiter's view. The slave modport is the requesters plus the memory slave.
interface capture_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int ADDR_WIDTH = 34,
  parameter int ID_WIDTH   = 6
);
  logic [NUM_REQ-1:0]            req_awvalid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_awaddr;
  logic [NUM_REQ-1:0]            req_awready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ*KEEP_WIDTH-1:0] req_wstrb;
  logic [NUM_REQ-1:0]            req_wvalid;
  logic [NUM_REQ-1:0]            req_wready;
  logic [NUM_REQ-1:0]            req_bvalid;
  logic [1:0]                    req_bresp;

  logic [ID_WIDTH-1:0]           m_axi_awid;
  logic [ADDR_WIDTH-1:0]         m_axi_awaddr;
  logic [7:0]                    m_axi_awlen;
  logic [2:0]                    m_axi_awsize;
  logic [1:0]                    m_axi_awburst;
  logic                          m_axi_awvalid;
  logic                          m_axi_awready;
  logic [DATA_WIDTH-1:0]         m_axi_wdata;
  logic [KEEP_WIDTH-1:0]         m_axi_wstrb;
  logic                          m_axi_wlast;
  logic                          m_axi_wvalid;
  logic                          m_axi_wready;
  logic [ID_WIDTH-1:0]           m_axi_bid;
  logic [1:0]                    m_axi_bresp;
  logic                          m_axi_bvalid;
  logic                          m_axi_bready;

  modport master (
    input  req_awvalid, req_awaddr, req_wdata, req_wstrb, req_wvalid,
    output req_awready, req_wready, req_bvalid, req_bresp,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output req_awvalid, req_awaddr, req_wdata, req_wstrb, req_wvalid,
    input  req_awready, req_wready, req_bvalid, req_bresp,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );
endinterface

// File: rtl/capture_wr_arbiter.sv
// Round-robin arbiter that funnels single-beat capture writes from NUM_REQ requesters
// onto one AXI write master, with exactly one transaction in flight at a time.
module capture_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int ADDR_WIDTH = 34,
  parameter int ID_WIDTH   = 6
) (
  input  logic                  m_axi_aclk,
  input  logic                  rst_n,
  capture_wr_arbiter_if.master  bus,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  err_sticky,
  output logic [ID_WIDTH-1:0]   err_id,
  output logic [31:0]           txn_count
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      win_idx, last_winner, rr_idx, rr_cand;
  logic                  rr_found;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [ID_WIDTH-1:0]   awid_q;
  logic                  awvalid_q;
  logic [NUM_REQ-1:0]    bvalid_q;
  logic [1:0]            bresp_q;
  logic                  aw_hs, w_hs, b_hs, txn_err;

  assign aw_hs   = (state == ADDR) && bus.m_axi_awready;
  assign w_hs    = (state == DATA) && bus.req_wvalid[win_idx] && bus.m_axi_wready;
  assign b_hs    = (state == RESP) && bus.m_axi_bvalid;
  assign txn_err = (bus.m_axi_bresp != 2'b00) || (bus.m_axi_bid != awid_q);

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_cand = IDX_W'((int'(last_winner) + i) % NUM_REQ);
      if (!rr_found && bus.req_awvalid[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  always_ff @(posedge m_axi_aclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rr_found) state_nxt = ADDR;
      ADDR:    if (aw_hs)    state_nxt = DATA;
      DATA:    if (w_hs)     state_nxt = RESP;
      RESP:    if (b_hs)     state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  // Address and ID are captured at grant time so they cannot move mid-transaction.
  always_ff @(posedge m_axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      win_idx     <= '0;
      last_winner <= IDX_W'(NUM_REQ - 1);
      awaddr_q    <= '0;
      awid_q      <= '0;
      awvalid_q   <= 1'b0;
      bvalid_q    <= '0;
      bresp_q     <= 2'b00;
      txn_count   <= '0;
      err_sticky  <= 1'b0;
      err_id      <= '0;
    end else begin
      bvalid_q <= '0;
      case (state)
        IDLE: if (rr_found) begin
          grant       <= NUM_REQ'(1) << rr_idx;
          win_idx     <= rr_idx;
          last_winner <= rr_idx;
          awaddr_q    <= bus.req_awaddr[int'(rr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          awid_q      <= ID_WIDTH'(rr_idx);
          awvalid_q   <= 1'b1;
        end
        ADDR: if (aw_hs) awvalid_q <= 1'b0;
        RESP: if (b_hs) begin
          bvalid_q  <= grant;
          bresp_q   <= bus.m_axi_bresp;
          txn_count <= txn_count + 32'd1;
          grant     <= '0;
          if (txn_err && !err_sticky) begin
            err_sticky <= 1'b1;
            err_id     <= awid_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_awready  = '0;
    bus.req_wready   = '0;
    bus.m_axi_wvalid = 1'b0;
    bus.m_axi_bready = (state == RESP);
    bus.m_axi_wdata  = bus.req_wdata[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
    bus.m_axi_wstrb  = bus.req_wstrb[int'(win_idx)*KEEP_WIDTH +: KEEP_WIDTH];
    case (state)
      ADDR: bus.req_awready[win_idx] = bus.m_axi_awready;
      DATA: begin
        bus.m_axi_wvalid             = bus.req_wvalid[win_idx];
        bus.req_wready[win_idx]      = bus.m_axi_wready;
      end
      default: ;
    endcase
  end

  assign bus.m_axi_awid    = awid_q;
  assign bus.m_axi_awaddr  = awaddr_q;
  assign bus.m_axi_awvalid = awvalid_q;
  assign bus.m_axi_awlen   = 8'd0;
  assign bus.m_axi_awsize  = 3'd6;
  assign bus.m_axi_awburst = 2'd1;
  assign bus.m_axi_wlast   = bus.m_axi_wvalid;
  assign bus.req_bvalid    = bvalid_q;
  assign bus.req_bresp     = bresp_q;
endmodule

// File: tb/tb_capture_wr_arbiter.sv
// Directed bench for capture_wr_arbiter: single writes, AW stall, error capture,
// reset during a write, and round-robin fairness with all requesters active.
module tb_capture_wr_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 64;
  localparam int KEEP_WIDTH = 8;
  localparam int ADDR_WIDTH = 34;
  localparam int ID_WIDTH   = 6;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NUM_REQ-1:0]  grant;
  logic                err_sticky;
  logic [ID_WIDTH-1:0] err_id;
  logic [31:0]         txn_count;

  logic                awready_en;
  logic [1:0]          bresp_val;
  logic [ID_WIDTH-1:0] bid_xor;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  capture_wr_arbiter_if #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .ID_WIDTH(ID_WIDTH)
  ) bus ();

  capture_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH), .ID_WIDTH(ID_WIDTH)
  ) dut (
    .m_axi_aclk (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .grant      (grant),
    .err_sticky (err_sticky),
    .err_id     (err_id),
    .txn_count  (txn_count)
  );

  // Zero-wait memory slave with knobs for AW stall, error response and bad BID.
  assign bus.m_axi_awready = awready_en;
  assign bus.m_axi_wready  = 1'b1;
  assign bus.m_axi_bvalid  = bus.m_axi_bready;
  assign bus.m_axi_bresp   = bresp_val;
  assign bus.m_axi_bid     = bus.m_axi_awid ^ bid_xor;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Raise one request, drop it once granted, and stop on the negedge showing req_bvalid.
  task automatic applyStimulus(input int idx, input logic [ADDR_WIDTH-1:0] addr);
    int n;
    bus.req_awaddr[idx*ADDR_WIDTH +: ADDR_WIDTH] = addr;
    bus.req_awvalid[idx] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (grant != '0) bus.req_awvalid = '0;
    end while (bus.req_bvalid == '0 && n < 20);
    if (bus.req_bvalid == '0) checkOutput("bvalid_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_bvalid();
    int n;
    n = 0;
    while (bus.req_bvalid == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.req_bvalid == '0) checkOutput("bvalid_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NUM_REQ-1:0] seen [5];
    logic [NUM_REQ-1:0] exp_order [5];
    logic [NUM_REQ-1:0] prev;
    int n;

    bus.req_awvalid = '0;
    bus.req_awaddr  = '0;
    bus.req_wvalid  = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH] = 64'hA5A5_0000_0000_0000 | 64'(i);
      bus.req_wstrb[i*KEEP_WIDTH +: KEEP_WIDTH] = 8'hF0 | 8'(i);
    end
    awready_en = 1'b1;
    bresp_val  = 2'b00;
    bid_xor    = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_grant",   64'(grant), 64'd0);
    checkOutput("rst_awvalid", 64'(bus.m_axi_awvalid), 64'd0);
    checkOutput("rst_bready",  64'(bus.m_axi_bready), 64'd0);
    checkOutput("rst_awaddr",  64'(bus.m_axi_awaddr), 64'd0);
    checkOutput("rst_txn",     64'(txn_count), 64'd0);
    checkOutput("rst_err",     64'(err_sticky), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request from req0, zero-wait slave, cycle by cycle.
    bus.req_awaddr[0 +: ADDR_WIDTH] = 34'h1000;
    bus.req_awvalid = 4'b0001;
    @(negedge clk);
    checkOutput("t1_awvalid", 64'(bus.m_axi_awvalid), 64'd1);
    checkOutput("t1_awaddr",  64'(bus.m_axi_awaddr), 64'h1000);
    checkOutput("t1_awid",    64'(bus.m_axi_awid), 64'd0);
    checkOutput("t1_grant",   64'(grant), 64'b0001);
    checkOutput("t1_awready", 64'(bus.req_awready), 64'b0001);
    checkOutput("t1_awlen",   64'(bus.m_axi_awlen), 64'd0);
    checkOutput("t1_awsize",  64'(bus.m_axi_awsize), 64'd6);
    checkOutput("t1_awburst", 64'(bus.m_axi_awburst), 64'd1);
    bus.req_awvalid = '0;
    @(negedge clk);
    checkOutput("t1_wvalid",  64'(bus.m_axi_wvalid), 64'd1);
    checkOutput("t1_wlast",   64'(bus.m_axi_wlast), 64'd1);
    checkOutput("t1_wdata",   64'(bus.m_axi_wdata), 64'hA5A5_0000_0000_0000);
    checkOutput("t1_wstrb",   64'(bus.m_axi_wstrb), 64'hF0);
    checkOutput("t1_wready",  64'(bus.req_wready), 64'b0001);
    checkOutput("t1_aw_low",  64'(bus.m_axi_awvalid), 64'd0);
    @(negedge clk);
    checkOutput("t1_bready",  64'(bus.m_axi_bready), 64'd1);
    checkOutput("t1_no_bv",   64'(bus.req_bvalid), 64'd0);
    @(negedge clk);
    checkOutput("t1_bvalid",  64'(bus.req_bvalid), 64'b0001);
    checkOutput("t1_bresp",   64'(bus.req_bresp), 64'd0);
    checkOutput("t1_txn",     64'(txn_count), 64'd1);
    checkOutput("t1_gclr",    64'(grant), 64'd0);
    @(negedge clk);
    checkOutput("t1_bv_pulse", 64'(bus.req_bvalid), 64'd0);

    // AW stall on req1, request dropped before the address handshake.
    awready_en = 1'b0;
    bus.req_awaddr[ADDR_WIDTH +: ADDR_WIDTH] = 34'h2000;
    bus.req_awvalid = 4'b0010;
    @(negedge clk);
    bus.req_awvalid = '0;
    for (int k = 0; k < 5; k++) begin
      checkOutput("t2_awvalid", 64'(bus.m_axi_awvalid), 64'd1);
      checkOutput("t2_awaddr",  64'(bus.m_axi_awaddr), 64'h2000);
      checkOutput("t2_grant",   64'(grant), 64'b0010);
      checkOutput("t2_no_data", 64'(bus.m_axi_wvalid), 64'd0);
      if (k < 4) @(negedge clk);
    end
    awready_en = 1'b1;
    wait_bvalid();
    checkOutput("t2_bvalid", 64'(bus.req_bvalid), 64'b0010);
    checkOutput("t2_txn",    64'(txn_count), 64'd2);

    // SLVERR on req2 latches the error, a later OKAY on req3 keeps it.
    bresp_val = 2'd2;
    applyStimulus(2, 34'h3000);
    checkOutput("t3_bvalid", 64'(bus.req_bvalid), 64'b0100);
    checkOutput("t3_bresp",  64'(bus.req_bresp), 64'd2);
    checkOutput("t3_err",    64'(err_sticky), 64'd1);
    checkOutput("t3_errid",  64'(err_id), 64'd2);
    checkOutput("t3_txn",    64'(txn_count), 64'd3);
    bresp_val = 2'd0;
    applyStimulus(3, 34'h4000);
    checkOutput("t3b_bvalid", 64'(bus.req_bvalid), 64'b1000);
    checkOutput("t3b_bresp",  64'(bus.req_bresp), 64'd0);
    checkOutput("t3b_err",    64'(err_sticky), 64'd1);
    checkOutput("t3b_errid",  64'(err_id), 64'd2);
    checkOutput("t3b_txn",    64'(txn_count), 64'd4);

    // Reset asserted while req0 is in the data phase.
    @(negedge clk);
    bus.req_awaddr[0 +: ADDR_WIDTH] = 34'h1800;
    bus.req_awvalid = 4'b0001;
    @(negedge clk);
    bus.req_awvalid = '0;
    @(negedge clk);
    checkOutput("t4_in_data", 64'(bus.m_axi_wvalid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t4_grant",   64'(grant), 64'd0);
    checkOutput("t4_wvalid",  64'(bus.m_axi_wvalid), 64'd0);
    checkOutput("t4_wready",  64'(bus.req_wready), 64'd0);
    checkOutput("t4_awvalid", 64'(bus.m_axi_awvalid), 64'd0);
    checkOutput("t4_awaddr",  64'(bus.m_axi_awaddr), 64'd0);
    checkOutput("t4_txn",     64'(txn_count), 64'd0);
    checkOutput("t4_err",     64'(err_sticky), 64'd0);
    checkOutput("t4_errid",   64'(err_id), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("t4_no_bv",   64'(bus.req_bvalid), 64'd0);

    // All requesters active: order restarts at req0 after reset.
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seen = '{default: '0};
    prev = '0;
    n = 0;
    bus.req_awvalid = 4'b1111;
    for (int c = 0; c < 60 && n < 5; c++) begin
      @(negedge clk);
      if (grant != '0 && prev == '0) begin
        seen[n] = grant;
        n++;
      end
      prev = grant;
    end
    bus.req_awvalid = '0;
    for (int i = 0; i < 5; i++) checkOutput($sformatf("t5_order%0d", i), 64'(seen[i]), 64'(exp_order[i]));
    wait_bvalid();
    checkOutput("t5_bvalid", 64'(bus.req_bvalid), 64'b0001);
    checkOutput("t5_txn",    64'(txn_count), 64'd5);

    // Mismatched BID on req1 is also an error.
    bid_xor = 6'd1;
    applyStimulus(1, 34'h5000);
    bid_xor = '0;
    checkOutput("t6_bvalid", 64'(bus.req_bvalid), 64'b0010);
    checkOutput("t6_err",    64'(err_sticky), 64'd1);
    checkOutput("t6_errid",  64'(err_id), 64'd1);
    checkOutput("t6_txn",    64'(txn_count), 64'd6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/capture_wr_arbiter.md
CAPTURE_WR_ARBITER -- requirements
Module: capture_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of capture requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 512, write data width in bits.
REQ-003 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, strobe width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 34, AXI address width.
REQ-005 SHALL have parameter ID_WIDTH, default 6, AXI ID width (>= clog2(NUM_REQ)).
REQ-006 Ports SHALL be: m_axi_aclk in 1, sole clock; rst_n in 1, asynchronous active-low reset.
REQ-007 Ports SHALL be: req_awvalid in NUM_REQ; req_awaddr in NUM_REQ*ADDR_WIDTH; req_awready out NUM_REQ.
REQ-008 Ports SHALL be: req_wdata in NUM_REQ*DATA_WIDTH; req_wstrb in NUM_REQ*KEEP_WIDTH; req_wvalid in NUM_REQ; req_wready out NUM_REQ.
REQ-009 Ports SHALL be: req_bvalid out NUM_REQ; req_bresp out 2, response to the granted requester.
REQ-010 Ports SHALL be: m_axi_awid out ID_WIDTH; m_axi_awaddr out ADDR_WIDTH; m_axi_awlen out 8; m_axi_awsize out 3; m_axi_awburst out 2; m_axi_awvalid out 1; m_axi_awready in 1.
REQ-011 Ports SHALL be: m_axi_wdata out DATA_WIDTH; m_axi_wstrb out KEEP_WIDTH; m_axi_wlast out 1; m_axi_wvalid out 1; m_axi_wready in 1.
REQ-012 Ports SHALL be: m_axi_bid in ID_WIDTH; m_axi_bresp in 2; m_axi_bvalid in 1; m_axi_bready out 1.
REQ-013 Ports SHALL be: grant out NUM_REQ, one-hot current owner; err_sticky out 1; err_id out ID_WIDTH; txn_count out 32.

Function
REQ-014 SHALL implement FSM IDLE, ADDR, DATA, RESP; exactly one single-beat write in flight.
REQ-015 IDLE: if any req_awvalid, SHALL select winner round-robin, register grant, awid=index, awaddr=winner address, assert m_axi_awvalid next cycle, enter ADDR.
REQ-016 Round-robin SHALL search from (last_winner+1) mod NUM_REQ upward; after reset last_winner=NUM_REQ-1, so requester 0 has top priority.
REQ-017 ADDR: req_awready[winner]=m_axi_awready combinationally; on m_axi_awvalid&m_axi_awready SHALL deassert m_axi_awvalid and enter DATA.
REQ-018 DATA: m_axi_wvalid=req_wvalid[winner], wdata/wstrb muxed from winner, req_wready[winner]=m_axi_wready; on handshake enter RESP.
REQ-019 RESP: m_axi_bready=1; on m_axi_bvalid SHALL pulse req_bvalid[winner] one cycle with req_bresp=m_axi_bresp, increment txn_count, clear grant, return to IDLE.
REQ-020 Constants SHALL be m_axi_awlen=0, m_axi_awsize=6, m_axi_awburst=1; m_axi_wlast SHALL equal m_axi_wvalid.
REQ-021 Non-granted requesters SHALL see awready, wready, bvalid all 0; address/data of a granted requester SHALL not change mid-transaction.
REQ-022 bresp!=0 or m_axi_bid!=awid SHALL set err_sticky and load err_id=awid (first error only); cleared only by reset.
REQ-023 txn_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-024 Requester dropping req_awvalid before address handshake SHALL not abort; arbiter holds grant until transaction completes.
REQ-025 Minimum transaction time SHALL be 4 cycles (IDLE, ADDR, DATA, RESP) with zero-wait slave; back-to-back grants without idle gap beyond IDLE cycle.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, grant=0, all valid/ready outputs 0, m_axi_awaddr=0, awid=0, txn_count=0, err_sticky=0, err_id=0, last_winner=NUM_REQ-1.
REQ-027 Reset mid-transaction SHALL abandon it with no req_bvalid pulse; release synchronous to m_axi_aclk.

Verification
REQ-028 Req0 only, addr 0x1000, slave zero-wait -> awaddr 0x1000, awid 0, req_bvalid[0] pulse 4 cycles after request, txn_count=1.
REQ-029 Req0..3 all asserted continuously -> grant order 0,1,2,3,0; no requester starved.
REQ-030 awready held low 5 cycles in ADDR -> m_axi_awvalid stable high, awaddr stable, no DATA entry.
REQ-031 Slave returns bresp=2 for req2 -> req_bresp=2 on req_bvalid[2], err_sticky=1, err_id=2; later OKAY keeps err_id=2.
REQ-032 rst_n asserted during DATA -> all outputs to reset values same cycle; next request from req0 granted first.
